// File: rtl/sd_dat_block_reader_if.sv
// Bus bundle for sd_dat_block_reader.
// Groups the register-slave port and the received-byte stream.
//   address/chipselect/write_n/writedata : register writes from the system bus
//   readdata                             : registered read data, 1-cycle latency
//   out_data/out_valid/out_ready         : received byte stream (valid/ready)
// The slave modport is used by the block; master is used by whoever drives it.
interface sd_dat_block_reader_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid
  );
endinterface

// File: rtl/sd_dat_block_reader.sv
// Single-block reader for the 4-bit SD DAT bus.
// Generates sd_clk, waits for the start bit, assembles nibbles into bytes on a
// valid/ready stream, checks the per-line CRC16 and the end bit, and exposes
// control/status through a small register slave.
// Ports:
//   clk    : system clock (only clock domain)
//   reset  : synchronous, active-high
//   bus    : register slave + byte stream (sd_dat_block_reader_if.slave)
//   sd_dat : DAT[3:0], already synchronized to clk
//   sd_clk : SD clock, registered
//
// state        | meaning
// S_IDLE       | sd_clk held low, waiting for a start write
// S_WAIT_START | sd_clk running, looking for DAT == 4'b0000
// S_DATA       | shifting 2*BLOCK_BYTES nibbles, updating CRCs
// S_CRC        | 16 samples compared against the computed CRCs
// S_END        | one sample, every line must be 1
module sd_dat_block_reader #(
  parameter int CLK_DIV     = 2,
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  sd_dat_block_reader_if.slave   bus,
  input  logic [3:0]             sd_dat,
  output logic                   sd_clk
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int NIB   = 2 * BLOCK_BYTES;
  localparam int NIB_W = $clog2(NIB);
  localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);
  localparam logic [NIB_W-1:0] NIB_LOAD = NIB_W'(NIB - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [NIB_W-1:0] nib_cnt;
  logic [3:0]       crc_cnt;
  logic [15:0]      crc [4];
  logic [3:0]       hi_nib;
  logic             pend;
  logic             done, timeout, end_err;
  logic [3:0]       crc_err;
  logic [CNT_W-1:0] byte_cnt;
  logic             stall, strobe, wr_ctl;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // A pending byte freezes the low phase of sd_clk, so no sample can be lost.
  assign stall  = bus.out_valid && !bus.out_ready;
  assign strobe = (state != S_IDLE) && !sd_clk && !stall && (div_cnt == '0);
  assign wr_ctl = bus.chipselect && !bus.write_n && (bus.address == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      sd_clk       <= 1'b0;
      div_cnt      <= DIV_LOAD;
      to_cnt       <= TO_LOAD;
      nib_cnt      <= NIB_LOAD;
      crc_cnt      <= 4'd15;
      for (int i = 0; i < 4; i++) crc[i] <= 16'h0000;
      hi_nib       <= 4'h0;
      pend         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      end_err      <= 1'b0;
      crc_err      <= 4'h0;
      byte_cnt     <= '0;
      bus.readdata <= 32'h0;
      bus.out_data <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      case (bus.address)
        2'd0:    bus.readdata <= {24'h0, crc_err, end_err, timeout, done, state != S_IDLE};
        2'd1:    bus.readdata <= {{(32-CNT_W){1'b0}}, byte_cnt};
        default: bus.readdata <= 32'h0;
      endcase

      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        byte_cnt      <= byte_cnt + 1'b1;
      end
      // out_valid rises one edge after the second-nibble strobe.
      if (pend) begin
        bus.out_valid <= 1'b1;
        pend          <= 1'b0;
      end

      // A high phase always completes; only the rising edge waits on stall.
      if (state != S_IDLE) begin
        if (sd_clk) begin
          if (div_cnt == '0) begin
            sd_clk  <= 1'b0;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end else if (!stall) begin
          if (div_cnt == '0) begin
            sd_clk  <= 1'b1;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          sd_clk  <= 1'b0;
          div_cnt <= DIV_LOAD;
          if (wr_ctl && bus.writedata[0] && !bus.writedata[1]) begin
            done     <= 1'b0;
            timeout  <= 1'b0;
            end_err  <= 1'b0;
            crc_err  <= 4'h0;
            byte_cnt <= '0;
            to_cnt   <= TO_LOAD;
            state    <= S_WAIT_START;
          end
        end
        S_WAIT_START: if (strobe) begin
          if (sd_dat == 4'b0000) begin
            state   <= S_DATA;
            nib_cnt <= NIB_LOAD;
            for (int i = 0; i < 4; i++) crc[i] <= 16'h0000;
          end else if (to_cnt == '0) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_DATA: if (strobe) begin
          for (int i = 0; i < 4; i++) crc[i] <= crc16_step(crc[i], sd_dat[i]);
          // nib_cnt counts down from an odd value, so bit 0 marks the high nibble.
          if (nib_cnt[0]) begin
            hi_nib <= sd_dat;
          end else begin
            bus.out_data <= {hi_nib, sd_dat};
            pend         <= 1'b1;
          end
          if (nib_cnt == '0) begin
            state   <= S_CRC;
            crc_cnt <= 4'd15;
          end else begin
            nib_cnt <= nib_cnt - 1'b1;
          end
        end
        S_CRC: if (strobe) begin
          for (int i = 0; i < 4; i++) begin
            if (sd_dat[i] != crc[i][15]) crc_err[i] <= 1'b1;
            crc[i] <= {crc[i][14:0], 1'b0};
          end
          if (crc_cnt == 4'd0) state <= S_END;
          else                 crc_cnt <= crc_cnt - 1'b1;
        end
        S_END: if (strobe) begin
          if (sd_dat != 4'hF) end_err <= 1'b1;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Abort overrides everything except the status flags and byte count.
      if (wr_ctl && bus.writedata[1]) begin
        state         <= S_IDLE;
        bus.out_valid <= 1'b0;
        pend          <= 1'b0;
        sd_clk        <= 1'b0;
        div_cnt       <= DIV_LOAD;
      end
    end
  end
endmodule

// File: tb/tb_sd_dat_block_reader.sv
module tb_sd_dat_block_reader;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sd_dat;
  logic       sd_clk;

  sd_dat_block_reader_if bus();

  sd_dat_block_reader #(.CLK_DIV(1), .BLOCK_BYTES(512), .TIMEOUT(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sd_dat (sd_dat),
    .sd_clk (sd_clk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Card model: symbol k is presented until the k-th sd_clk rising edge after load.
  logic [3:0] sym [2048];
  int         card_len  = 0;
  int         card_base = 0;
  int         strobe_cnt = 0;
  int         card_pos;
  logic [10:0] card_idx;

  always @(posedge sd_clk) strobe_cnt <= strobe_cnt + 1;

  assign card_pos = strobe_cnt - card_base;
  assign card_idx = card_pos[10:0];
  assign sd_dat   = (card_pos >= 0 && card_pos < card_len) ? sym[card_idx] : 4'hF;

  // Stream monitor.
  logic [7:0] rx_mem [4096];
  int         rx_n = 0;
  int         valid_cnt = 0;
  logic [11:0] rx_wi;
  assign rx_wi = rx_n[11:0];

  always @(negedge clk) begin
    if (bus.out_valid) valid_cnt <= valid_cnt + 1;
    if (bus.out_valid && bus.out_ready) begin
      rx_mem[rx_wi] <= bus.out_data;
      rx_n          <= rx_n + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic int bad_bytes(input int base);
    int bad;
    logic [11:0] idx;
    logic [7:0]  exp_b;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      idx   = 12'(base + i);
      exp_b = 8'(i);
      if (rx_mem[idx] !== exp_b) bad++;
    end
    return bad;
  endfunction

  task automatic card_load(input int pre, input bit flip);
    logic [15:0] c [4];
    logic [7:0]  b;
    logic [3:0]  nb;
    logic [3:0]  cn;
    int n;
    for (int i = 0; i < 4; i++) c[i] = 16'h0000;
    n = 0;
    for (int i = 0; i < pre; i++) begin sym[11'(n)] = 4'hF; n++; end
    sym[11'(n)] = 4'h0; n++;
    for (int k = 0; k < 1024; k++) begin
      b  = 8'(k / 2);
      nb = (k % 2 == 0) ? b[7:4] : b[3:0];
      sym[11'(n)] = nb; n++;
      for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], nb[i]);
    end
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 4; i++) cn[i] = c[i][15-j];
      if (flip && j == 5) cn[2] = ~cn[2];
      sym[11'(n)] = cn; n++;
    end
    sym[11'(n)] = 4'hF; n++;
    card_len  = n;
    card_base = strobe_cnt;
  endtask

  task automatic card_idle();
    card_len  = 0;
    card_base = strobe_cnt;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'h0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1 bus.address = a;
    @(posedge clk); #1 d = bus.readdata;
    bus.address = 2'd0;
  endtask

  task automatic wait_rx(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (rx_n >= n) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_rx: got %0d bytes, need %0d", rx_n, n); end
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      reg_read(2'd0, st);
      if (st[0] == 1'b0) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_idle: busy never cleared, status %h", st); end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int rb;
    card_load(3, 0);
    rb = rx_n;
    reg_write(2'd0, 32'h1);
    wait_rx(rb + 10);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (sd_clk !== 1'b0) begin errors++; $display("FAIL reset_sd_clk: got %b want 0", sd_clk); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", bus.readdata); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
    reg_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", rd); end
  endtask

  task automatic test_good_block();
    logic [31:0] rd;
    int rb, s0, bad;
    card_load(3, 0);
    rb = rx_n; s0 = strobe_cnt;
    reg_write(2'd0, 32'h1);
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL good_busy: got %h want 1", rd); end
    wait_rx(rb + 100);
    reg_write(2'd0, 32'h1);
    wait_idle();
    checks++; if (rx_n - rb != 512) begin errors++; $display("FAIL good_len: got %0d want 512", rx_n - rb); end
    bad = bad_bytes(rb);
    checks++; if (bad != 0) begin errors++; $display("FAIL good_data: got %0d bad bytes want 0", bad); end
    checks++; if (strobe_cnt - s0 != 1045) begin errors++; $display("FAIL good_strobes: got %0d want 1045", strobe_cnt - s0); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL good_status: got %h want 2", rd); end
    reg_read(2'd1, rd);
    checks++; if (rd !== 32'd512) begin errors++; $display("FAIL good_count: got %0d want 512", rd); end
    reg_read(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL addr2: got %h want 0", rd); end
    reg_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL addr3: got %h want 0", rd); end
    reg_write(2'd1, 32'h1);
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL write_addr1: got %h want 2", rd); end
  endtask

  task automatic test_crc_error();
    logic [31:0] rd;
    int rb, bad;
    card_load(5, 1);
    rb = rx_n;
    reg_write(2'd0, 32'h1);
    wait_idle();
    checks++; if (rx_n - rb != 512) begin errors++; $display("FAIL crc_len: got %0d want 512", rx_n - rb); end
    bad = bad_bytes(rb);
    checks++; if (bad != 0) begin errors++; $display("FAIL crc_data: got %0d bad bytes want 0", bad); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h42) begin errors++; $display("FAIL crc_status: got %h want 42", rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int s0, vb;
    card_idle();
    s0 = strobe_cnt; vb = valid_cnt;
    reg_write(2'd0, 32'h1);
    wait_idle();
    checks++; if (strobe_cnt - s0 != 64) begin errors++; $display("FAIL to_strobes: got %0d want 64", strobe_cnt - s0); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL to_status: got %h want 4", rd); end
    checks++; if (valid_cnt != vb) begin errors++; $display("FAIL to_valid: got %0d valid cycles want 0", valid_cnt - vb); end
    reg_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL to_count: got %0d want 0", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic [7:0]  d0;
    int rb, s0, sc0, bad;
    bit got;
    card_load(3, 0);
    rb = rx_n; s0 = strobe_cnt;
    reg_write(2'd0, 32'h1);
    wait_rx(rb + 20);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_valid: got out_valid 0 want 1"); end
    d0 = bus.out_data; sc0 = strobe_cnt; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || sd_clk !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    checks++; if (strobe_cnt != sc0) begin errors++; $display("FAIL bp_strobes: got %0d strobes want 0", strobe_cnt - sc0); end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_idle();
    checks++; if (rx_n - rb != 512) begin errors++; $display("FAIL bp_len: got %0d want 512", rx_n - rb); end
    bad = bad_bytes(rb);
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_data: got %0d bad bytes want 0", bad); end
    checks++; if (strobe_cnt - s0 != 1045) begin errors++; $display("FAIL bp_total_strobes: got %0d want 1045", strobe_cnt - s0); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL bp_status: got %h want 2", rd); end
  endtask

  task automatic test_abort_start();
    logic [31:0] rd;
    int rb, bad;
    card_load(3, 0);
    rb = rx_n;
    reg_write(2'd0, 32'h1);
    wait_rx(rb + 30);
    reg_write(2'd0, 32'h3);
    checks++; if (sd_clk !== 1'b0) begin errors++; $display("FAIL abort_sd_clk: got %b want 0", sd_clk); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.out_valid); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_status: got %h want 0", rd); end
    reg_read(2'd1, rd);
    checks++; if (rd !== 32'(rx_n - rb)) begin errors++; $display("FAIL abort_count: got %0d want %0d", rd, rx_n - rb); end
    card_load(2, 0);
    rb = rx_n;
    reg_write(2'd0, 32'h1);
    wait_idle();
    checks++; if (rx_n - rb != 512) begin errors++; $display("FAIL restart_len: got %0d want 512", rx_n - rb); end
    bad = bad_bytes(rb);
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_data: got %0d bad bytes want 0", bad); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL restart_status: got %h want 2", rd); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    test_reset();
    test_good_block();
    test_crc_error();
    test_timeout();
    test_backpressure();
    test_abort_start();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_dat_block_reader.md
# sd_dat_block_reader

Hardware sequencer for the 4-bit SD DAT bus: it replaces software bit-banging of the DAT pins for single-block reads. It drives the SD clock, waits for the start bit, shifts 4-bit nibbles into bytes delivered on a valid/ready stream, checks per-line CRC16 and the end bit, and reports status through a small register slave on the system bus.

## Interface
- CLK_DIV, 2: clk cycles per sd_clk half-period; legal values ≥1.
- BLOCK_BYTES, 512: data bytes per block; must be ≥1.
- TIMEOUT, 4096: sd_clk samples allowed in WAIT_START before timeout; must be ≥1.
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- sd_dat  in  4  DAT[3:0] from the pads, already synchronized.
- sd_clk  out  1  SD clock, registered.
- out_data  out  8  received byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.

## Operation
- Registers:
  - Write address 0: bit0 = start, bit1 = abort.
  - Read address 0: [0] busy, [1] done, [2] timeout, [3] end_err, [7:4] crc_err per line; other bits 0.
  - Read address 1: bytes delivered in the current/last block, zero-extended.
  - Addresses 2–3 read 0. Writes to addresses 1–3 are ignored.
- States:
  - IDLE: sd_clk held 0.
  - WAIT_START: sd_clk runs. A sample of sd_dat == 4'b0000 → DATA. A sample count reaching TIMEOUT → IDLE with timeout=1.
  - DATA: 2*BLOCK_BYTES samples. First nibble of each byte goes to [7:4], second to [3:0]. After the last data sample → CRC.
  - CRC: 16 samples. Line i's received bit is compared MSB-first with its computed CRC; any mismatch sets crc_err[i]. Then → END.
  - END: 1 sample. Any line ≠ 1 sets end_err. Then → IDLE with done=1.
- Start:
  - Honoured only in IDLE. It clears done, timeout, end_err, crc_err and the byte count, then enters WAIT_START.
  - Start while busy is ignored.
- Abort: valid from any state. Next state is IDLE, out_valid is cleared, sd_clk goes 0, and status flags are unchanged. If start and abort are written together, abort wins.
- CRC: CRC16-CCITT (x^16+x^12+x^5+1), one independent register per line, initialised to 0 on entry to DATA, updated on every DATA sample of that line.
- Stream handshake:
  - A byte transfers when out_valid && out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - The byte count increments on each transfer.
- busy = (state ≠ IDLE).

## Timing
- Reset values:
  - sd_clk=0, out_valid=0, out_data=0, readdata=0.
  - State IDLE, all status flags and the byte count 0.
- Clock generation: sd_clk toggles every CLK_DIV clk cycles while running.
- Sampling: a sample strobe is the clk edge on which sd_clk goes 0→1. sd_dat is sampled on that same edge.
- Stall:
  - While out_valid=1 and out_ready=0, the divider freezes.
  - If sd_clk is high, it completes its high phase and is then held low.
  - No sample strobe occurs until the byte is accepted, so no data is lost.
- Byte output: out_valid rises on the clk edge after the strobe that captured the second nibble.
- readdata reflects the address presented one clk earlier (1-cycle latency) and is updated every cycle.
- Boundaries:
  - The last byte must be accepted before the first CRC sample can occur.
  - done and busy=0 appear on the edge after the END sample.
  - Reset mid-block returns every output to its reset value on the next edge.

## Test plan
- Reset: assert reset for 3 cycles mid-DATA. → sd_clk=0, out_valid=0, readdata=0, status 0 on the next edge.
- Good block (CLK_DIV=1, out_ready=1): bytes 0x00..0xFF repeated twice, correct CRCs, end bit 1. → 512 bytes delivered in order; status reads done=1, crc_err=0, end_err=0, busy=0; address 1 reads 512.
- CRC error: flip one CRC bit on DAT2. → all 512 bytes still delivered; crc_err=4'b0100, done=1.
- Timeout (TIMEOUT=64): DAT held 4'b1111. → IDLE after exactly 64 strobes; timeout=1, done=0, out_valid never asserted.
- Backpressure: drop out_ready for 10 cycles while out_valid=1. → sd_clk stays low, out_data constant, no strobes; the stream resumes with no byte lost or duplicated.
- Abort + start: write 0x3 at address 0 mid-DATA. → IDLE next edge, sd_clk=0, out_valid=0; a later start (0x1) runs a good block normally.
